// File: rtl/multi_button_shaper.sv
// Multi-channel conditioner for active-low push buttons.
// Each channel has a 2-flop synchroniser, press/release debounce, a one-clock press pulse and optional auto-repeat.
module multi_button_shaper #(
  parameter int NUM_CH     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int REP_EN     = 0,
  parameter int REP_DELAY  = 500,
  parameter int REP_PERIOD = 100,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] B_In,
  output logic [NUM_CH-1:0] B_Out,
  output logic [NUM_CH-1:0] B_Held
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DEB_PRS = 2'd1,
    S_HELD    = 2'd2,
    S_DEB_REL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_DELAY - 1);
  // After each repeat the counter restarts so that it needs REP_PERIOD more cycles
  // to reach REP_DELAY. A period longer than the delay clamps the restart value to zero.
  localparam logic [CNT_W-1:0] REP_RELOAD =
    CNT_W'((REP_PERIOD > REP_DELAY) ? 0 : (REP_DELAY - REP_PERIOD));

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;

  // The synchroniser resets to all ones, which reads as every button released.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= B_In;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] rcnt;
    logic             pulse;
    logic             held;

    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        state <= S_IDLE;
        dcnt  <= '0;
        rcnt  <= '0;
        pulse <= 1'b0;
        held  <= 1'b0;
      end else begin
        pulse <= 1'b0;
        case (state)
          S_IDLE: begin
            if (!sync2[i]) begin
              state <= S_DEB_PRS;
              dcnt  <= ONE;
            end
          end
          S_DEB_PRS: begin
            if (sync2[i]) begin
              state <= S_IDLE;
              dcnt  <= '0;
            end else if (dcnt < DEB_MAX) begin
              dcnt <= dcnt + ONE;
            end else begin
              state <= S_HELD;
              pulse <= 1'b1;
              held  <= 1'b1;
              rcnt  <= '0;
            end
          end
          S_HELD: begin
            if (sync2[i]) begin
              state <= S_DEB_REL;
              dcnt  <= ONE;
            end else if (REP_EN != 0) begin
              if (rcnt >= REP_LAST) begin
                pulse <= 1'b1;
                rcnt  <= REP_RELOAD;
              end else begin
                rcnt <= rcnt + ONE;
              end
            end
          end
          S_DEB_REL: begin
            // Falling back to S_HELD keeps rcnt, so repeat timing resumes.
            if (!sync2[i]) begin
              state <= S_HELD;
            end else if (dcnt < DEB_MAX) begin
              dcnt <= dcnt + ONE;
            end else begin
              state <= S_IDLE;
              held  <= 1'b0;
              dcnt  <= '0;
            end
          end
          default: begin
            state <= S_IDLE;
            pulse <= 1'b0;
            held  <= 1'b0;
            dcnt  <= '0;
            rcnt  <= '0;
          end
        endcase
      end
    end

    assign B_Out[i]  = pulse;
    assign B_Held[i] = held;
  end

endmodule

// File: tb/tb_multi_button_shaper.sv
// Directed bench for multi_button_shaper: one instance without repeat, one with repeat.
module tb_multi_button_shaper;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] a_in = 4'hF;
  logic [3:0] a_out;
  logic [3:0] a_held;
  logic [3:0] b_in = 4'hF;
  logic [3:0] b_out;
  logic [3:0] b_held;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  multi_button_shaper #(
    .NUM_CH(4), .DEB_CYCLES(4), .REP_EN(0), .REP_DELAY(10), .REP_PERIOD(5), .CNT_W(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .B_In(a_in), .B_Out(a_out), .B_Held(a_held)
  );

  multi_button_shaper #(
    .NUM_CH(4), .DEB_CYCLES(4), .REP_EN(1), .REP_DELAY(10), .REP_PERIOD(5), .CNT_W(8)
  ) dut_rep (
    .Clk(Clk), .Rst(Rst), .B_In(b_in), .B_Out(b_out), .B_Held(b_held)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    logic [3:0] pat;

    repeat (3) tick();
    chk("reset_out_a", 32'(a_out), 32'h0);
    chk("reset_held_a", 32'(a_held), 32'h0);
    chk("reset_out_b", 32'(b_out), 32'h0);
    Rst = 1'b1;
    repeat (5) tick();
    chk("idle_out_a", 32'(a_out), 32'h0);
    chk("idle_held_b", 32'(b_held), 32'h0);

    // T1: press ch0; it is sampled on the next edge (j=0), pulse follows edge j=6
    a_in[0] = 1'b0;
    tick();
    for (int j = 1; j <= 9; j++) begin
      tick();
      chk($sformatf("t1_out j=%0d", j), 32'(a_out), (j == 6) ? 32'h1 : 32'h0);
      chk($sformatf("t1_held j=%0d", j), 32'(a_held), (j >= 6) ? 32'h1 : 32'h0);
    end
    a_in[0] = 1'b1;
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("t1_rel_out j=%0d", j), 32'(a_out), 32'h0);
      chk($sformatf("t1_rel_held j=%0d", j), 32'(a_held), (j < 6) ? 32'h1 : 32'h0);
    end

    // T2: bounce 0,0,0,1,0,0,0,1 on ch1 never gets accepted
    pat = 4'b1000;
    for (int j = 0; j < 8; j++) begin
      a_in[1] = pat[j % 4];
      tick();
      chk($sformatf("t2_bounce j=%0d", j), 32'(a_out), 32'h0);
    end
    a_in[1] = 1'b1;
    repeat (4) begin
      tick();
      chk("t2_bounce_tail", 32'(a_out | a_held), 32'h0);
    end
    pulses = 0;
    a_in[1] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (a_out[1]) pulses++;
    end
    chk("t2_steady_pulses", 32'(pulses), 32'd1);
    chk("t2_steady_held", 32'(a_held), 32'h2);
    a_in[1] = 1'b1;
    repeat (10) tick();
    chk("t2_released", 32'(a_held), 32'h0);

    // T4: long hold without repeat, then a 2-cycle release glitch
    pulses = 0;
    a_in[3] = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      tick();
      if (a_out[3]) pulses++;
    end
    chk("t4_long_pulses", 32'(pulses), 32'd1);
    chk("t4_long_held", 32'(a_held), 32'h8);
    a_in[3] = 1'b1;
    tick();
    tick();
    a_in[3] = 1'b0;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (a_out[3]) pulses++;
      chk($sformatf("t4_glitch_held j=%0d", j), 32'(a_held[3]), 32'h1);
    end
    chk("t4_glitch_pulses", 32'(pulses), 32'd0);
    a_in[3] = 1'b1;
    repeat (10) tick();
    chk("t4_released", 32'(a_held), 32'h0);

    // T5: simultaneous press of ch0 and ch3
    a_in = 4'b0110;
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("t5_out j=%0d", j), 32'(a_out), (j == 6) ? 32'h9 : 32'h0);
    end
    chk("t5_held", 32'(a_held), 32'h9);
    a_in = 4'hF;
    repeat (10) tick();
    chk("t5_released", 32'(a_held), 32'h0);

    // T3: auto-repeat on ch2 (press pulse at j=6, then +10,+15,+20,+25,+30)
    b_in[2] = 1'b0;
    tick();
    for (int j = 1; j <= 36; j++) begin
      tick();
      chk($sformatf("t3_out j=%0d", j), 32'(b_out),
          (j == 6 || j == 16 || j == 21 || j == 26 || j == 31 || j == 36) ? 32'h4 : 32'h0);
    end
    b_in[2] = 1'b1;
    for (int j = 37; j <= 48; j++) begin
      tick();
      chk($sformatf("t3_rel_out j=%0d", j), 32'(b_out), 32'h0);
      chk($sformatf("t3_rel_held j=%0d", j), 32'(b_held), (j < 43) ? 32'h4 : 32'h0);
    end

    // T6: ch2 held and ch1 mid-debounce when reset is asserted asynchronously
    a_in[2] = 1'b0;
    repeat (12) tick();
    chk("t6_pre_held", 32'(a_held), 32'h4);
    a_in[1] = 1'b0;
    repeat (3) tick();
    #2 Rst = 1'b0;
    #1;
    chk("t6_async_held", 32'(a_held), 32'h0);
    chk("t6_async_out", 32'(a_out), 32'h0);
    tick();
    Rst = 1'b1;
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("t6_out j=%0d", j), 32'(a_out), (j == 6) ? 32'h6 : 32'h0);
    end
    chk("t6_held", 32'(a_held), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
